alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, 74S181-compatible ALU with a built-in iterative multiply/divide sequencer. Generalises the fixed 32-bit, 8-slice datapath to any multiple-of-4 width. Adds a registered result stage and a start/busy/done handshake, so one block serves single-cycle ALU ops and WIDTH-step unsigned multiply and divide. Sits in the CADR datapath where the ALU and Q-register step logic live today.

## Interface
- WIDTH, 32, datapath width; must be a multiple of 4 and at least 8
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- a  in  WIDTH  A-bus operand (74181 B input); multiplier / dividend
- m  in  WIDTH  M-bus operand (74181 A input); multiplicand / divisor
- aluf  in  4  74181 S select
- alumode  in  1  74181 M (1 = logic, 0 = arithmetic)
- cin0  in  1  active-high carry into bit 0 (ALU op only)
- op  in  2  0 = ALU, 1 = MUL, 2 = DIV, 3 = reserved (treated as ALU)
- start  in  1  request; sampled only when busy = 0
- busy  out  1  sequencer running MUL/DIV
- done  out  1  one-cycle pulse, results valid
- res_lo  out  WIDTH  ALU F / product low / quotient
- res_hi  out  WIDTH  0 / product high / remainder
- res_x  out  1  ALU extension bit (alu[WIDTH]); 0 for MUL/DIV
- aeqm  out  1  ALU op: F[WIDTH-1:0] all ones; else 0
- div0  out  1  last DIV had m = 0

## Operation
- ALU function: exact 74S181 active-high table, A = m, B = a, S = aluf, M = alumode. Ripple carry across WIDTH/4 slices, cin0 into slice 0; carry ignored in logic mode.
- res_x: a 1-bit slice on A = m[WIDTH-1], B = a[WIDTH-1] (upper inputs zero), carry-in = carry out of bit WIDTH-1.
- aeqm: AND of all slice AEB outputs, registered with the result.
- MUL (unsigned): load acc = 0 (WIDTH+1 bits), q = a, mc = m. Each step computes sum = acc + (q[0] ? mc : 0), then {acc, q} = {sum, q} >> 1. After WIDTH steps, res_hi = acc[WIDTH-1:0], res_lo = q.
- DIV (unsigned restoring): load rem = 0, q = a, d = m. Each step shifts {rem, q} left 1 and computes t = rem - d (WIDTH+1 bits). If t is non-negative, rem = t and q[0] = 1. Final state: res_lo = q, res_hi = rem.
- DIV with m = 0: no iteration. res_lo = all ones, res_hi = a, div0 = 1.
- div0 is cleared by any accepted start whose op is not a zero-divisor DIV.
- States: IDLE, RUN, DONE. RUN steps are counted by a $clog2(WIDTH)+1-bit counter.
- Outputs hold their values until the next accepted start.

## Timing
- Reset value of every output: 0. State: IDLE, counter 0.
- Start is accepted at edge k when busy = 0.
- ALU and DIV-by-zero: results, aeqm and done = 1 in cycle k+1; busy stays 0.
- MUL/DIV: busy = 1 in cycles k+1 .. k+WIDTH, with one step per edge k+1 .. k+WIDTH. In cycle k+WIDTH+1: done = 1, busy = 0, results valid.
- start while busy = 1 is ignored; operand changes during RUN are ignored because operands are latched at acceptance.
- start in a done cycle is accepted, back-to-back with no bubble.
- Reset mid-RUN aborts immediately: all outputs 0, no done pulse.

## Structure
- Shared package `cadr_alu_pkg` holds:
  - op encodings ALU_OP_ALU, ALU_OP_MUL, ALU_OP_DIV
  - the state enum
  - named aluf constants: ALUF_ADD = 4'b1001, ALUF_SUB = 4'b0110, ALUF_PASSM = 4'b1111 with alumode = 1
- One sub-module, `alu181_slice`: a behavioural 4-bit 74S181 (F, X, Y, COUT_N, AEB) instantiated WIDTH/4 times plus once for res_x. The MUL/DIV adder is a separate plain WIDTH+1-bit add/sub.

## Test plan
- ALU add: m=5, a=3, aluf=1001, alumode=0, cin0=0 -> next cycle res_lo=8, res_x=0, aeqm=0, done=1, busy=0.
- ALU compare: m=a=0x1234, aluf=0110, alumode=0, cin0=0 -> res_lo=0xFFFFFFFF, aeqm=1, res_x=1. Repeat with cin0=1 -> res_lo=0, aeqm=0.
- MUL: a=m=0xFFFFFFFF -> busy high 32 cycles, done in cycle 33, res_hi=0xFFFFFFFE, res_lo=0x00000001. A start pulsed mid-run is ignored.
- DIV: a=100, m=7 -> done in cycle 33, res_lo=14, res_hi=2, div0=0. Then a=100, m=0 -> done next cycle, res_lo=0xFFFFFFFF, res_hi=100, div0=1.
- Back-to-back: MUL started in the done cycle of the previous DIV -> accepted, new done exactly 33 cycles later.
- Reset asserted at step 10 of a MUL -> all outputs 0 asynchronously, no done. A later ALU op works normally. Rerun all cases with WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/cadr_alu_pkg.sv
// Shared encodings for the CADR ALU / multiply-divide block: op codes, sequencer
// states and the commonly used 74181 function selects.
package cadr_alu_pkg;

  localparam logic [1:0] ALU_OP_ALU = 2'd0;
  localparam logic [1:0] ALU_OP_MUL = 2'd1;
  localparam logic [1:0] ALU_OP_DIV = 2'd2;

  // ADD/SUB are arithmetic (alumode = 0); SUB needs cin0 = 1 for a true A - B.
  // PASSM is a logic-mode select (alumode = 1).
  localparam logic [3:0] ALUF_ADD   = 4'b1001;
  localparam logic [3:0] ALUF_SUB   = 4'b0110;
  localparam logic [3:0] ALUF_PASSM = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/alu181_slice.sv
// Behavioural 4-bit 74S181, active-high data. Carry in/out are active-low as on the
// real part; x_o/y_o are the active-low group propagate/generate outputs.
module alu181_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] s_i,
  input  logic       m_i,
  input  logic       cin_n_i,
  output logic [3:0] f_o,
  output logic       x_o,
  output logic       y_o,
  output logic       cout_n_o,
  output logic       aeb_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    // Arithmetic result is p + g + carry; g only ever sets bits already set in p.
    p = a_i | (b_i & {4{s_i[0]}}) | (~b_i & {4{s_i[1]}});
    g = (a_i & ~b_i & {4{s_i[2]}}) | (a_i & b_i & {4{s_i[3]}});
    c = '0;
    c[0] = ~cin_n_i;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    f_o      = m_i ? ~(p ^ g) : (p ^ g ^ c[3:0]);
    x_o      = ~&p;
    y_o      = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    cout_n_o = ~c[4];
    aeb_o    = &f_o;
  end

endmodule

// File: rtl/alu_mdu.sv
// 74S181-compatible ALU of WIDTH bits plus an iterative unsigned multiply /
// restoring divide sequencer, with a registered result stage and start/busy/done.
module alu_mdu
  import cadr_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] m,
  input  logic [3:0]       aluf,
  input  logic             alumode,
  input  logic             cin0,
  input  logic [1:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             res_x,
  output logic             aeqm,
  output logic             div0
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned CntW      = $clog2(WIDTH) + 1;

  // ALU datapath: ripple chain of 181 slices plus a 1-bit extension slice.
  logic [WIDTH-1:0]     alu_f;
  logic [NumSlices:0]   carry_n;
  logic [NumSlices-1:0] slice_x, slice_y, slice_aeb;
  logic [3:0]           ext_f;
  logic                 ext_x, ext_y, ext_cout_n, ext_aeb;
  logic                 unused_alu;

  assign carry_n[0] = ~cin0;

  for (genvar i = 0; i < NumSlices; i++) begin : g_slice
    alu181_slice u_slice (
      .a_i      (m[4*i +: 4]),
      .b_i      (a[4*i +: 4]),
      .s_i      (aluf),
      .m_i      (alumode),
      .cin_n_i  (carry_n[i]),
      .f_o      (alu_f[4*i +: 4]),
      .x_o      (slice_x[i]),
      .y_o      (slice_y[i]),
      .cout_n_o (carry_n[i+1]),
      .aeb_o    (slice_aeb[i])
    );
  end

  alu181_slice u_ext_slice (
    .a_i      ({3'b000, m[WIDTH-1]}),
    .b_i      ({3'b000, a[WIDTH-1]}),
    .s_i      (aluf),
    .m_i      (alumode),
    .cin_n_i  (carry_n[NumSlices]),
    .f_o      (ext_f),
    .x_o      (ext_x),
    .y_o      (ext_y),
    .cout_n_o (ext_cout_n),
    .aeb_o    (ext_aeb)
  );

  assign unused_alu = ^{slice_x, slice_y, ext_f[3:1], ext_x, ext_y, ext_cout_n, ext_aeb};

  // Sequencer state
  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             res_x_q, res_x_d;
  logic             aeqm_q, aeqm_d;
  logic             div0_q, div0_d;

  // Shared add/sub for one MUL or DIV step
  logic [WIDTH:0]   rem_s, add_lhs, add_rhs, add_sum, acc_n;
  logic [WIDTH-1:0] q_n;

  always_comb begin
    rem_s   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    add_lhs = is_div_q ? rem_s : acc_q;
    add_rhs = is_div_q ? ~{1'b0, d_q} : (q_q[0] ? {1'b0, d_q} : '0);
    add_sum = add_lhs + add_rhs + {{WIDTH{1'b0}}, is_div_q};
    if (is_div_q) begin
      // Top bit of rem - d set means the trial subtraction went negative: restore.
      acc_n = add_sum[WIDTH] ? rem_s : add_sum;
      q_n   = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
    end else begin
      acc_n = {1'b0, add_sum[WIDTH:1]};
      q_n   = {add_sum[0], q_q[WIDTH-1:1]};
    end
  end

  logic accept;
  assign accept = start && (state_q != StRun);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    q_d      = q_q;
    d_d      = d_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    res_x_d  = res_x_q;
    aeqm_d   = aeqm_q;
    div0_d   = div0_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          div0_d = 1'b0;
          if (op == ALU_OP_MUL || (op == ALU_OP_DIV && m != '0)) begin
            state_d  = StRun;
            cnt_d    = '0;
            is_div_d = (op == ALU_OP_DIV);
            acc_d    = '0;
            q_d      = a;
            d_d      = m;
          end else if (op == ALU_OP_DIV) begin
            state_d  = StDone;
            res_lo_d = '1;
            res_hi_d = a;
            res_x_d  = 1'b0;
            aeqm_d   = 1'b0;
            div0_d   = 1'b1;
          end else begin
            state_d  = StDone;
            res_lo_d = alu_f;
            res_hi_d = '0;
            res_x_d  = ext_f[0];
            aeqm_d   = &slice_aeb;
          end
        end
      end
      StRun: begin
        acc_d = acc_n;
        q_d   = q_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = StDone;
          res_lo_d = q_n;
          res_hi_d = acc_n[WIDTH-1:0];
          res_x_d  = 1'b0;
          aeqm_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      q_q      <= '0;
      d_q      <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      res_x_q  <= 1'b0;
      aeqm_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      d_q      <= d_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      res_x_q  <= res_x_d;
      aeqm_q   <= aeqm_d;
      div0_q   <= div0_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign res_lo = res_lo_q;
  assign res_hi = res_hi_q;
  assign res_x  = res_x_q;
  assign aeqm   = aeqm_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: vector table driven through a scoreboard queue, an independent
// 74181 function-table model, and hand sequences for mid-run start and reset abort.
module tb_alu_mdu;
  import cadr_alu_pkg::*;

  localparam int unsigned W = 32;  // 8..32, multiple of 4
  localparam logic [W-1:0] Ones = '1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, m;
  logic [3:0]   aluf;
  logic         alumode, cin0, start;
  logic [1:0]   op;
  logic         busy, done, res_x, aeqm, div0;
  logic [W-1:0] res_lo, res_hi;

  alu_mdu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .m       (m),
    .aluf    (aluf),
    .alumode (alumode),
    .cin0    (cin0),
    .op      (op),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .res_lo  (res_lo),
    .res_hi  (res_hi),
    .res_x   (res_x),
    .aeqm    (aeqm),
    .div0    (div0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         x;
    logic         eq;
    logic         dz;
    int unsigned  lat;
  } exp_t;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [3:0]   s;
    logic         mode;
    logic         cin;
    exp_t         e;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // 74181 arithmetic table on n-bit operands (A = x, B = y); result has carry at bit n.
  function automatic logic [63:0] arith181(logic [3:0] s, logic [63:0] x, logic [63:0] y,
                                           int n, logic c);
    logic [63:0] k, aa, bb, nb, r;
    k  = (64'd1 << n) - 64'd1;
    aa = x & k;
    bb = y & k;
    nb = ~y & k;
    case (s)
      4'h0:    r = aa;
      4'h1:    r = aa | bb;
      4'h2:    r = aa | nb;
      4'h3:    r = k;
      4'h4:    r = aa + (aa & nb);
      4'h5:    r = (aa | bb) + (aa & nb);
      4'h6:    r = aa + nb;
      4'h7:    r = (aa & nb) + k;
      4'h8:    r = aa + (aa & bb);
      4'h9:    r = aa + bb;
      4'hA:    r = (aa | nb) + (aa & bb);
      4'hB:    r = (aa & bb) + k;
      4'hC:    r = aa + aa;
      4'hD:    r = (aa | bb) + aa;
      4'hE:    r = (aa | nb) + aa;
      default: r = aa + k;
    endcase
    return r + {63'd0, c};
  endfunction

  function automatic logic [63:0] logic181(logic [3:0] s, logic [63:0] x, logic [63:0] y,
                                           int n);
    logic [63:0] k, r;
    k = (64'd1 << n) - 64'd1;
    case (s)
      4'h0:    r = ~x;
      4'h1:    r = ~(x | y);
      4'h2:    r = ~x & y;
      4'h3:    r = 64'd0;
      4'h4:    r = ~(x & y);
      4'h5:    r = ~y;
      4'h6:    r = x ^ y;
      4'h7:    r = x & ~y;
      4'h8:    r = ~x | y;
      4'h9:    r = ~(x ^ y);
      4'hA:    r = y;
      4'hB:    r = x & y;
      4'hC:    r = ~64'd0;
      4'hD:    r = x | ~y;
      4'hE:    r = x | y;
      default: r = x;
    endcase
    return r & k;
  endfunction

  function automatic exp_t model(logic [1:0] o, logic [W-1:0] av, logic [W-1:0] mv,
                                 logic [3:0] s, logic md, logic c);
    exp_t        e;
    logic [63:0] r, rx, prod;
    e.lo = '0; e.hi = '0; e.x = 1'b0; e.eq = 1'b0; e.dz = 1'b0; e.lat = 1;
    if (o == ALU_OP_MUL) begin
      prod  = 64'(av) * 64'(mv);
      e.lo  = prod[W-1:0];
      e.hi  = prod[2*W-1:W];
      e.lat = W + 1;
    end else if (o == ALU_OP_DIV) begin
      if (mv == '0) begin
        e.lo = Ones;
        e.hi = av;
        e.dz = 1'b1;
      end else begin
        e.lo  = av / mv;
        e.hi  = av % mv;
        e.lat = W + 1;
      end
    end else begin
      if (md) begin
        r  = logic181(s, 64'(mv), 64'(av), W);
        rx = logic181(s, 64'(mv[W-1]), 64'(av[W-1]), 1);
      end else begin
        r  = arith181(s, 64'(mv), 64'(av), W, c);
        rx = arith181(s, 64'(mv[W-1]), 64'(av[W-1]), 1, r[W]);
      end
      e.lo = r[W-1:0];
      e.x  = rx[0];
      e.eq = &e.lo;
    end
    return e;
  endfunction

  function automatic vec_t mk(string nm, logic [1:0] o, logic [W-1:0] av, logic [W-1:0] mv,
                              logic [3:0] s, logic md, logic c);
    vec_t v;
    v.name = nm; v.op = o; v.a = av; v.m = mv; v.s = s; v.mode = md; v.cin = c;
    v.e = model(o, av, mv, s, md, c);
    return v;
  endfunction

  // Call at a negedge; returns at the negedge of the done cycle (or after the bound).
  task automatic run(vec_t v, bit poke);
    int unsigned n;
    bit          got;
    exp_t        e;
    op = v.op; a = v.a; m = v.m; aluf = v.s; alumode = v.mode; cin0 = v.cin; start = 1'b1;
    sb_q.push_back(v.e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    got = 1'b0;
    while (n <= W + 4 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (n == 1) chk({v.name, "/busy_run"}, 64'(busy), 64'(v.e.lat > 1));
        if (poke && n == 5) begin
          op = ALU_OP_ALU; a = '0; m = '0; aluf = ALUF_ADD; alumode = 1'b0; start = 1'b1;
        end
        if (poke && n == 6) start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    e = sb_q.pop_front();
    chk({v.name, "/latency"}, 64'(n), 64'(e.lat));
    chk({v.name, "/busy_done"}, 64'(busy), 64'd0);
    chk({v.name, "/res_lo"}, 64'(res_lo), 64'(e.lo));
    chk({v.name, "/res_hi"}, 64'(res_hi), 64'(e.hi));
    chk({v.name, "/res_x"}, 64'(res_x), 64'(e.x));
    chk({v.name, "/aeqm"}, 64'(aeqm), 64'(e.eq));
    chk({v.name, "/div0"}, 64'(div0), 64'(e.dz));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   ndone;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; m = '0; aluf = '0; alumode = 1'b0;
    cin0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset/lo", 64'(res_lo), 64'd0);
    chk("reset/hi", 64'(res_hi), 64'd0);
    chk("reset/flags", 64'({busy, done, res_x, aeqm, div0}), 64'd0);

    // Literal expectations for the headline cases, model-derived for the rest.
    v = mk("add", ALU_OP_ALU, W'(3), W'(5), ALUF_ADD, 1'b0, 1'b0);
    v.e.lo = W'(8); v.e.x = 1'b0; v.e.eq = 1'b0;
    tbl.push_back(v);
    v = mk("cmp_eq", ALU_OP_ALU, W'(32'h1234), W'(32'h1234), ALUF_SUB, 1'b0, 1'b0);
    v.e.lo = Ones; v.e.x = 1'b1; v.e.eq = 1'b1;
    tbl.push_back(v);
    v = mk("cmp_cin", ALU_OP_ALU, W'(32'h1234), W'(32'h1234), ALUF_SUB, 1'b0, 1'b1);
    v.e.lo = '0; v.e.eq = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk("passm", ALU_OP_ALU, W'(32'h0F0F), W'(32'hA5A5A5A5), ALUF_PASSM,
                     1'b1, 1'b1));
    tbl.push_back(mk("xor", ALU_OP_ALU, W'(32'h0FF0_3C3C), W'(32'hF0F0_5A5A), 4'b0110,
                     1'b1, 1'b0));
    tbl.push_back(mk("inc_wrap", ALU_OP_ALU, W'(0), Ones, 4'b0000, 1'b0, 1'b1));
    tbl.push_back(mk("dec_zero", ALU_OP_ALU, W'(0), W'(0), 4'b1111, 1'b0, 1'b0));
    tbl.push_back(mk("op3_add", 2'd3, W'(32'h7FFF_FFFF), W'(32'h0000_0001), ALUF_ADD,
                     1'b0, 1'b0));
    tbl.push_back(mk("mul_small", ALU_OP_MUL, W'(9), W'(7), 4'b0000, 1'b0, 1'b0));
    v = mk("div", ALU_OP_DIV, W'(100), W'(7), 4'b0000, 1'b0, 1'b0);
    v.e.lo = W'(14); v.e.hi = W'(2); v.e.dz = 1'b0;
    tbl.push_back(v);
    // Started in the done cycle of the DIV above: latency check proves no bubble.
    tbl.push_back(mk("mul_b2b", ALU_OP_MUL, W'(32'h1357_9BDF), W'(32'h0246_8ACE), 4'b0000,
                     1'b0, 1'b0));
    v = mk("div0", ALU_OP_DIV, W'(100), W'(0), 4'b0000, 1'b0, 1'b0);
    v.e.lo = Ones; v.e.hi = W'(100); v.e.dz = 1'b1;
    tbl.push_back(v);
    tbl.push_back(mk("div0_clear", ALU_OP_ALU, W'(1), W'(2), ALUF_ADD, 1'b0, 1'b0));
    tbl.push_back(mk("div_by1", ALU_OP_DIV, Ones, W'(1), 4'b0000, 1'b0, 1'b0));
    tbl.push_back(mk("div_small", ALU_OP_DIV, W'(3), W'(10), 4'b0000, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk($sformatf("rnd_alu%0d", i), ALU_OP_ALU, W'($urandom()), W'($urandom()),
                       4'($urandom_range(15)), 1'($urandom_range(1)),
                       1'($urandom_range(1))));
    end
    for (int i = 0; i < 3; i++) begin
      tbl.push_back(mk($sformatf("rnd_mul%0d", i), ALU_OP_MUL, W'($urandom()),
                       W'($urandom()), 4'b0000, 1'b0, 1'b0));
      tbl.push_back(mk($sformatf("rnd_div%0d", i), ALU_OP_DIV, W'($urandom()),
                       W'($urandom_range(1, 1000)), 4'b0000, 1'b0, 1'b0));
    end

    foreach (tbl[i]) run(tbl[i], 1'b0);

    // Full-scale multiply with a stray start pulsed mid-run.
    v = mk("mul_ones", ALU_OP_MUL, Ones, Ones, 4'b0000, 1'b0, 1'b0);
    v.e.lo = W'(1); v.e.hi = Ones - W'(1);
    run(v, 1'b1);

    // Leave non-zero results behind, then abort a MUL at step 10 with reset.
    run(mk("div0_pre", ALU_OP_DIV, W'(55), W'(0), 4'b0000, 1'b0, 1'b0), 1'b0);
    op = ALU_OP_MUL; a = Ones; m = Ones; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort/busy_before", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort/lo", 64'(res_lo), 64'd0);
    chk("abort/hi", 64'(res_hi), 64'd0);
    chk("abort/flags", 64'({busy, done, res_x, aeqm, div0}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("abort/no_done", 64'(ndone), 64'd0);
    v = mk("add_after_rst", ALU_OP_ALU, W'(3), W'(5), ALUF_ADD, 1'b0, 1'b0);
    v.e.lo = W'(8);
    run(v, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
